// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcodes, ALU operation codes and datapath mux select codes.
package mips_mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_wait_cnt.sv
// Memory wait counter: counts cycles without mem_ready in the current
// memory state and flags when MEM_TIMEOUT wait cycles have elapsed.
module mips_mc_wait_cnt #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic resetb,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_timeout
);
    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_max;

    assign w_at_max  = (r_cnt == CW'(MEM_TIMEOUT));
    assign o_timeout = w_at_max;

    // Clear has priority; counting stops at the timeout value.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !w_at_max)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: state/opcode registers plus combinational
// next-state and control decode, with a memory-wait timeout.
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       rf_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       mem_err,
    output logic       illegal_op,
    output logic [3:0] state
);
    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;
    logic       r_run;
    logic       w_timeout;
    logic       w_cnt_clr;

    assign state = r_state;

    // Restart the count on every state change, after a timeout, and while held idle.
    assign w_cnt_clr = (w_next != r_state) | mem_err | ~r_run;

    mips_mc_wait_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_cnt (
        .clk       (clk),
        .resetb    (resetb),
        .i_clr     (w_cnt_clr),
        .i_inc     (~mem_ready),
        .o_timeout (w_timeout)
    );

    // State, latched opcode and run flag; r_run keeps all outputs quiet until
    // the first rising edge after reset release.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
            r_run    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            if (r_run && r_state == S_DECODE)
                r_opcode <= opcode;
        end
    end

    // Next-state and control decode; mem_ready takes priority over timeout.
    always_comb begin
        w_next     = S_FETCH;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        rf_we      = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        mem_err    = 1'b0;
        illegal_op = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    mem_re    = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                    if (mem_ready)      w_next = S_DECODE;
                    else if (w_timeout) mem_err = 1'b1;
                    else                w_next = S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    case (opcode)
                        OP_RTYPE:      w_next = S_R_EXEC;
                        OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                        OP_BEQ:        w_next = S_BRANCH;
                        OP_J:          w_next = S_JUMP;
                        OP_ADDI:       w_next = S_I_EXEC;
                        default:       illegal_op = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    w_next    = (r_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_re = 1'b1;
                    iord   = 1'b1;
                    mdr_we = mem_ready;
                    if (mem_ready)      w_next = S_MEM_WB;
                    else if (w_timeout) mem_err = 1'b1;
                    else                w_next = S_MEM_RD;
                end
                S_MEM_WB: begin
                    rf_we      = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_we = 1'b1;
                    iord   = 1'b1;
                    if (!mem_ready) begin
                        if (w_timeout) mem_err = 1'b1;
                        else           w_next = S_MEM_WR;
                    end
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                    w_next    = S_R_WB;
                end
                S_R_WB: begin
                    rf_we   = 1'b1;
                    reg_dst = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PC_ALUOUT;
                    pc_we     = zero;
                end
                S_JUMP: begin
                    pc_src = PC_JUMP;
                    pc_we  = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    w_next    = S_I_WB;
                end
                S_I_WB: begin
                    rf_we = 1'b1;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: each driven cycle pushes its expected
// state and control word; a negedge monitor pops and compares.
module tb_mips_mc_ctrl;
    logic       clk;
    logic       resetb;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, ir_we, mdr_we, rf_we, mem_re, mem_we, iord;
    logic       reg_dst, mem_to_reg, alu_src_a, mem_err, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int n_chk = 0;
    int n_err = 0;

    mips_mc_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .resetb(resetb), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mdr_we(mdr_we),
        .rf_we(rf_we), .mem_re(mem_re), .mem_we(mem_we), .iord(iord),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .mem_err(mem_err), .illegal_op(illegal_op), .state(state)
    );

    // {err,ill}_{pc,ir,mdr,rf we}_{mem_re,mem_we,iord}_{reg_dst,m2r,src_a}_srcb_aluop_pcsrc
    logic [17:0] w_ctl;
    assign w_ctl = {mem_err, illegal_op, pc_we, ir_we, mdr_we, rf_we, mem_re, mem_we,
                    iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

    localparam logic [17:0] C_NONE    = 18'b0;
    localparam logic [17:0] F_RDY     = 18'b00_1100_100_000_01_00_00;
    localparam logic [17:0] F_WAIT    = 18'b00_0000_100_000_01_00_00;
    localparam logic [17:0] DEC       = 18'b00_0000_000_000_11_00_00;
    localparam logic [17:0] DEC_ILL   = 18'b01_0000_000_000_11_00_00;
    localparam logic [17:0] MADDR     = 18'b00_0000_000_001_10_00_00;
    localparam logic [17:0] MRD_RDY   = 18'b00_0010_101_000_00_00_00;
    localparam logic [17:0] MRD_WAIT  = 18'b00_0000_101_000_00_00_00;
    localparam logic [17:0] MWB       = 18'b00_0001_000_010_00_00_00;
    localparam logic [17:0] MWR       = 18'b00_0000_011_000_00_00_00;
    localparam logic [17:0] MWR_ERR   = 18'b10_0000_011_000_00_00_00;
    localparam logic [17:0] REX       = 18'b00_0000_000_001_00_10_00;
    localparam logic [17:0] RWB       = 18'b00_0001_000_100_00_00_00;
    localparam logic [17:0] BR_Z      = 18'b00_1000_000_001_00_01_01;
    localparam logic [17:0] BR_NZ     = 18'b00_0000_000_001_00_01_01;
    localparam logic [17:0] JMP       = 18'b00_1000_000_000_00_00_10;
    localparam logic [17:0] IEX       = 18'b00_0000_000_001_10_00_00;
    localparam logic [17:0] IWB       = 18'b00_0001_000_000_00_00_00;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [17:0] ctl;
    } sb_t;
    sb_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge and queue what must be seen.
    task automatic cyc(input string tag, input logic [5:0] op, input logic z,
                       input logic rdy, input logic [3:0] est, input logic [17:0] ectl);
        sb_t it;
        @(posedge clk);
        #1;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        it.tag = tag; it.st = est; it.ctl = ectl;
        sb_q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t it;
            it = sb_q.pop_front();
            chk({it.tag, "_st"}, 32'(state), 32'(it.st));
            chk({it.tag, "_ctl"}, 32'(w_ctl), 32'(it.ctl));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
        #1 resetb = 1'b0;
        #2;
        chk("rst_st", 32'(state), 32'd0);
        chk("rst_ctl", 32'(w_ctl), 32'(C_NONE));
        repeat (2) @(posedge clk);
        #1 chk("rst_hold_ctl", 32'(w_ctl), 32'(C_NONE));
        @(negedge clk);
        #1 resetb = 1'b1;
        #1 chk("rel_ctl", 32'(w_ctl), 32'(C_NONE));

        // R-type: 0,1,6,7
        cyc("r_f",   6'b000000, 0, 1, 4'd0, F_RDY);
        cyc("r_dec", 6'b000000, 0, 1, 4'd1, DEC);
        cyc("r_ex",  6'b000000, 0, 1, 4'd6, REX);
        cyc("r_wb",  6'b000000, 0, 1, 4'd7, RWB);
        // lw with two wait cycles in MEM_RD
        cyc("lw_f",   6'b100011, 0, 1, 4'd0, F_RDY);
        cyc("lw_dec", 6'b100011, 0, 1, 4'd1, DEC);
        cyc("lw_ad",  6'b100011, 0, 1, 4'd2, MADDR);
        cyc("lw_w0",  6'b000000, 0, 0, 4'd3, MRD_WAIT);
        cyc("lw_w1",  6'b000000, 0, 0, 4'd3, MRD_WAIT);
        cyc("lw_rd",  6'b000000, 0, 1, 4'd3, MRD_RDY);
        cyc("lw_wb",  6'b000000, 0, 1, 4'd4, MWB);
        // beq taken / not taken
        cyc("bz_f",   6'b000100, 1, 1, 4'd0, F_RDY);
        cyc("bz_dec", 6'b000100, 1, 1, 4'd1, DEC);
        cyc("bz_br",  6'b000100, 1, 1, 4'd8, BR_Z);
        cyc("bn_f",   6'b000100, 0, 1, 4'd0, F_RDY);
        cyc("bn_dec", 6'b000100, 0, 1, 4'd1, DEC);
        cyc("bn_br",  6'b000100, 0, 1, 4'd8, BR_NZ);
        // illegal opcode
        cyc("il_f",   6'b111111, 0, 1, 4'd0, F_RDY);
        cyc("il_dec", 6'b111111, 0, 1, 4'd1, DEC_ILL);
        // jump, with one fetch wait first
        cyc("j_fw",   6'b000010, 0, 0, 4'd0, F_WAIT);
        cyc("j_f",    6'b000010, 0, 1, 4'd0, F_RDY);
        cyc("j_dec",  6'b000010, 0, 1, 4'd1, DEC);
        cyc("j_jmp",  6'b000010, 0, 1, 4'd9, JMP);
        // addi
        cyc("ai_f",   6'b001000, 0, 1, 4'd0, F_RDY);
        cyc("ai_dec", 6'b001000, 0, 1, 4'd1, DEC);
        cyc("ai_ex",  6'b001000, 0, 1, 4'd10, IEX);
        cyc("ai_wb",  6'b001000, 0, 1, 4'd11, IWB);
        // sw zero-wait
        cyc("sw_f",   6'b101011, 0, 1, 4'd0, F_RDY);
        cyc("sw_dec", 6'b101011, 0, 1, 4'd1, DEC);
        cyc("sw_ad",  6'b101011, 0, 1, 4'd2, MADDR);
        cyc("sw_wr",  6'b101011, 0, 1, 4'd5, MWR);
        // sw timeout: 15 wait cycles, then mem_err
        cyc("to_f",   6'b101011, 0, 1, 4'd0, F_RDY);
        cyc("to_dec", 6'b101011, 0, 1, 4'd1, DEC);
        cyc("to_ad",  6'b101011, 0, 1, 4'd2, MADDR);
        for (int i = 0; i < 15; i++) cyc("to_wait", 6'b101011, 0, 0, 4'd5, MWR);
        cyc("to_err", 6'b101011, 0, 0, 4'd5, MWR_ERR);
        // ready on the timeout cycle wins
        cyc("tr_f",   6'b101011, 0, 1, 4'd0, F_RDY);
        cyc("tr_dec", 6'b101011, 0, 1, 4'd1, DEC);
        cyc("tr_ad",  6'b101011, 0, 1, 4'd2, MADDR);
        for (int i = 0; i < 15; i++) cyc("tr_wait", 6'b101011, 0, 0, 4'd5, MWR);
        cyc("tr_rdy", 6'b101011, 0, 1, 4'd5, MWR);
        // reset between edges in MEM_WR
        cyc("rs_f",   6'b101011, 0, 1, 4'd0, F_RDY);
        cyc("rs_dec", 6'b101011, 0, 1, 4'd1, DEC);
        cyc("rs_ad",  6'b101011, 0, 1, 4'd2, MADDR);
        cyc("rs_wr",  6'b101011, 0, 0, 4'd5, MWR);
        @(negedge clk);
        #2 resetb = 1'b0;
        #1;
        chk("mr_st", 32'(state), 32'd0);
        chk("mr_mem_we", 32'(mem_we), 32'd0);
        chk("mr_ctl", 32'(w_ctl), 32'(C_NONE));
        mem_ready = 1'b1;
        @(posedge clk);
        #1 chk("mr_hold_ctl", 32'(w_ctl), 32'(C_NONE));
        @(negedge clk);
        #1 resetb = 1'b1;
        #1 chk("mr_rel_ctl", 32'(w_ctl), 32'(C_NONE));
        cyc("rr_f",   6'b000000, 0, 1, 4'd0, F_RDY);
        cyc("rr_dec", 6'b000000, 0, 1, 4'd1, DEC);
        cyc("rr_ex",  6'b000000, 0, 1, 4'd6, REX);
        cyc("rr_wb",  6'b000000, 0, 1, 4'd7, RWB);
        cyc("end_f",  6'b000000, 0, 0, 4'd0, F_WAIT);
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles spent waiting for mem_ready in any memory state.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 resetb  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  IR[31:26]; sampled only in DECODE.
REQ-005 zero  input  1  ALU zero flag; sampled only in BRANCH.
REQ-006 mem_ready  input  1  memory handshake: access completes in the cycle it is high.
REQ-007 pc_we, ir_we, mdr_we, rf_we  output  1 each  register write enables for PC, IR, MDR and the register file.
REQ-008 mem_re, mem_we, iord  output  1 each  memory read strobe, memory write strobe, address select (0=PC, 1=ALUOut).
REQ-009 reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath mux selects.
REQ-010 alu_src_b, alu_op, pc_src  output  2 each  mux and ALU-control selects.
REQ-011 mem_err, illegal_op  output  1 each  single-cycle error pulses.
REQ-012 state  output  4  current state encoding, for debug.

Function
REQ-013 States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11; encodings 12-15 go to FETCH on the next edge.
REQ-014 FETCH: mem_re=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_we and pc_we equal mem_ready; go to DECODE when mem_ready=1, else stay.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: 000000->R_EXEC, 100011 or 101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000->I_EXEC.
REQ-016 DECODE with any other opcode: illegal_op=1 for that one cycle, then FETCH; no write enable asserted.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEM_RD if opcode was 100011, else MEM_WR (opcode latched in DECODE).
REQ-018 MEM_RD: mem_re=1, iord=1, mdr_we=mem_ready; go to MEM_WB on mem_ready. MEM_WB: rf_we=1, reg_dst=0, mem_to_reg=1; then FETCH.
REQ-019 MEM_WR: mem_we=1, iord=1 until mem_ready; go to FETCH on mem_ready.
REQ-020 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB. R_WB: rf_we=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=zero; then FETCH.
REQ-022 JUMP: pc_src=10, pc_we=1; then FETCH.
REQ-023 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; then I_WB. I_WB: rf_we=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-024 Any output not listed for a state is 0 in that state.
REQ-025 A wait counter clears on entry to FETCH, MEM_RD and MEM_WR, and increments each cycle mem_ready=0.
REQ-026 When the counter reaches MEM_TIMEOUT with mem_ready still 0: mem_err=1 for one cycle, no write enable asserted in that cycle, next state FETCH.
REQ-027 When mem_ready=1 and the timeout occur in the same cycle, mem_ready wins: normal completion, mem_err=0.
REQ-028 Cycle counts with zero-wait memory: R-type, addi 4; lw 5; sw 4; beq 3; j 3.

Reset
REQ-029 resetb=0 forces state=FETCH, wait counter=0, latched opcode=0 immediately, regardless of clk.
REQ-030 While resetb=0, all outputs are 0, including mem_re; the first FETCH strobe follows the first rising edge after release.
REQ-031 Reset asserted mid-instruction abandons it; no write enable is asserted after reset asserts.

Structure
REQ-032 A shared package holds the state encodings, opcode constants, alu_op codes (00 add, 01 sub, 10 funct) and the alu_src_b and pc_src select codes.
REQ-033 The state register and latched opcode use the existing asynchronous active-low DFF cell style; next-state and output decode are separate combinational logic.
REQ-034 One sub-module, mips_mc_wait_cnt, implements the wait counter and timeout flag.

Verification
REQ-035 Reset, then R-type (opcode 000000) with mem_ready tied 1 -> states 0,1,6,7,0; rf_we=1 and reg_dst=1 only in state 7.
REQ-036 lw (100011) with mem_ready low 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0; mdr_we=1 only in the third MEM_RD cycle.
REQ-037 beq (000100): zero=1 -> pc_we=1, pc_src=01 in BRANCH; zero=0 -> pc_we=0; both return to FETCH.
REQ-038 Opcode 111111 -> illegal_op pulse in DECODE, next state FETCH, no write enables asserted.
REQ-039 sw with mem_ready held 0 -> mem_err pulses after 15 wait cycles, then FETCH; and a run with mem_ready=1 on the timeout cycle -> no mem_err.
REQ-040 resetb to 0 between clock edges during MEM_WR -> state=0 and mem_we=0 immediately; after release, FETCH resumes with mem_re=1.
